// File: rtl/pc_redirect_unit_if.sv
// Request/response bundle between the pipeline control logic and the PC stage.
// The master drives redirect requests and stalls; the slave returns fetch PC and status pulses.
interface pc_redirect_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            busy_wait;
    logic            trap_en;
    logic [XLEN-1:0] trap_target;
    logic            branch_en;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_inc;
    logic            fetch_valid;
    logic            flush;
    logic            misalign;
    logic            pend_valid;

    modport master (
        output busy_wait, trap_en, trap_target, branch_en, branch_target,
        input  pc, pc_plus_inc, fetch_valid, flush, misalign, pend_valid
    );

    modport slave (
        input  busy_wait, trap_en, trap_target, branch_en, branch_target,
        output pc, pc_plus_inc, fetch_valid, flush, misalign, pend_valid
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with trap/branch redirects, a one-entry redirect buffer held across
// memory stalls, and flush/misalign pulses for the IF/ID stage.
module pc_redirect_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    pc_redirect_unit_if.slave bus
);
    localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_trap_q, pend_trap_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic            fetch_valid_q;

    logic            redirect;
    logic [XLEN-1:0] target;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_trap_d   = pend_trap_q;
        pend_target_d = pend_target_q;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;
        redirect      = 1'b0;
        target        = '0;

        if (bus.busy_wait) begin
            // A pending trap is never displaced by a branch; a newer branch replaces an older one.
            if (bus.trap_en) begin
                pend_valid_d  = 1'b1;
                pend_trap_d   = 1'b1;
                pend_target_d = bus.trap_target;
            end else if (bus.branch_en && !(pend_valid_q && pend_trap_q)) begin
                pend_valid_d  = 1'b1;
                pend_trap_d   = 1'b0;
                pend_target_d = bus.branch_target;
            end
        end else begin
            if (bus.trap_en) begin
                redirect = 1'b1;
                target   = bus.trap_target;
            end else if (pend_valid_q) begin
                redirect = 1'b1;
                target   = pend_target_q;
            end else if (bus.branch_en) begin
                redirect = 1'b1;
                target   = bus.branch_target;
            end

            if (redirect) begin
                pc_d         = {target[XLEN-1:2], 2'b00};
                flush_d      = 1'b1;
                misalign_d   = (target[1:0] != 2'b00);
                pend_valid_d = 1'b0;
            end else if (fetch_valid_q) begin
                // The release edge after reset holds RESET_VECTOR rather than stepping past it.
                pc_d = pc_q + INC_V;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
            fetch_valid_q <= 1'b1;
        end
    end

    // NOTE: the buffer payload is only read when pend_valid_q is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        pend_trap_q   <= pend_trap_d;
        pend_target_q <= pend_target_d;
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus_inc = pc_q + INC_V;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.flush       = flush_q;
    assign bus.misalign    = misalign_q;
    assign bus.pend_valid  = pend_valid_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: each driven cycle pushes its expected PC-stage
// state, which is popped and compared one clock edge later.
module tb_pc_redirect_unit;
    logic clk;
    logic reset;

    pc_redirect_unit_if #(.XLEN(32)) bus ();

    pc_redirect_unit #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .INC         (4)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic        misalign;
        logic        pend;
        logic        fetch_valid;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, then compare after the edge.
    task automatic step(input string tag, input logic rst, input logic busy,
                        input logic trap, input logic [31:0] ttgt,
                        input logic br, input logic [31:0] btgt,
                        input logic [31:0] e_pc, input logic e_flush, input logic e_mis,
                        input logic e_pend, input logic e_fv);
        exp_t e;
        exp_t o;
        logic [31:0] e_inc;
        reset             = rst;
        bus.busy_wait     = busy;
        bus.trap_en       = trap;
        bus.trap_target   = ttgt;
        bus.branch_en     = br;
        bus.branch_target = btgt;
        e = '{tag: tag, pc: e_pc, flush: e_flush, misalign: e_mis, pend: e_pend, fetch_valid: e_fv};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        e_inc = o.pc + 32'd4;
        check({o.tag, ".pc"},          bus.pc,                 o.pc);
        check({o.tag, ".pc_plus_inc"}, bus.pc_plus_inc,        e_inc);
        check({o.tag, ".flush"},       32'(bus.flush),         32'(o.flush));
        check({o.tag, ".misalign"},    32'(bus.misalign),      32'(o.misalign));
        check({o.tag, ".pend_valid"},  32'(bus.pend_valid),    32'(o.pend));
        check({o.tag, ".fetch_valid"}, 32'(bus.fetch_valid),   32'(o.fetch_valid));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.busy_wait     = 1'b0;
        bus.trap_en       = 1'b0;
        bus.trap_target   = '0;
        bus.branch_en     = 1'b0;
        bus.branch_target = '0;

        //   tag           rst busy trap ttgt         br   btgt         pc            fl   mis  pend fv
        step("rst0",       1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 0);
        step("rst1",       1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 0);
        step("release",    0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 1);
        step("seq4",       0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 0, 0, 1);
        step("seq8",       0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 0, 0, 0, 1);
        step("branch",     0, 0, 0, 32'h0,        1, 32'h100,      32'h0000_0100, 1, 0, 0, 1);
        step("after_br",   0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 0, 0, 0, 1);

        step("stall_br",   0, 1, 0, 32'h0,        1, 32'h200,      32'h0000_0104, 0, 0, 1, 1);
        step("stall2",     0, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 0, 0, 1, 1);
        step("stall3",     0, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 0, 0, 1, 1);
        step("pend_apply", 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0200, 1, 0, 0, 1);
        step("after_pend", 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0204, 0, 0, 0, 1);

        step("stall_trap", 0, 1, 1, 32'h80,       0, 32'h0,        32'h0000_0204, 0, 0, 1, 1);
        step("stall_brtr", 0, 1, 0, 32'h0,        1, 32'h300,      32'h0000_0204, 0, 0, 1, 1);
        step("trap_kept",  0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0080, 1, 0, 0, 1);
        step("after_trap", 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0084, 0, 0, 0, 1);

        step("trap_vs_br", 0, 0, 1, 32'h500,      1, 32'h600,      32'h0000_0500, 1, 0, 0, 1);
        step("after_tvb",  0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0504, 0, 0, 0, 1);
        step("busy_tvb",   0, 1, 1, 32'h700,      1, 32'h740,      32'h0000_0504, 0, 0, 1, 1);
        step("busy_tvb_r", 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0700, 1, 0, 0, 1);

        step("br_old",     0, 1, 0, 32'h0,        1, 32'h800,      32'h0000_0700, 0, 0, 1, 1);
        step("br_new",     0, 1, 0, 32'h0,        1, 32'h900,      32'h0000_0700, 0, 0, 1, 1);
        step("br_newest",  0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0900, 1, 0, 0, 1);

        step("pend_a00",   0, 1, 0, 32'h0,        1, 32'hA00,      32'h0000_0900, 0, 0, 1, 1);
        step("pend_vs_br", 0, 0, 0, 32'h0,        1, 32'hB00,      32'h0000_0A00, 1, 0, 0, 1);
        step("br_dropped", 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0A04, 0, 0, 0, 1);
        step("pend_c00",   0, 1, 0, 32'h0,        1, 32'hC00,      32'h0000_0A04, 0, 0, 1, 1);
        step("trap_vs_pd", 0, 0, 1, 32'hD00,      0, 32'h0,        32'h0000_0D00, 1, 0, 0, 1);
        step("pend_clr",   0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0D04, 0, 0, 0, 1);

        step("misalign",   0, 0, 0, 32'h0,        1, 32'h1002,     32'h0000_1000, 1, 1, 0, 1);
        step("mis_clear",  0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_1004, 0, 0, 0, 1);
        step("to_top",     0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 1);
        step("wrap",       0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 1);
        step("seq_w4",     0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 0, 0, 1);

        step("pend_400",   0, 1, 0, 32'h0,        1, 32'h400,      32'h0000_0004, 0, 0, 1, 1);
        step("rst_stall",  1, 1, 1, 32'h123,      1, 32'h456,      32'h0000_0000, 0, 0, 0, 0);
        step("rst_rel",    0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 1);
        step("no_400_a",   0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 0, 0, 1);
        step("no_400_b",   0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 0, 0, 0, 1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Parametrised program-counter stage for the RISC-V pipeline. It holds the fetch PC and advances it sequentially. It accepts trap and branch redirects with fixed priority. While the memory system asserts busy-wait, it buffers one redirect so none is lost. When a redirect is applied, it emits a flush pulse toward IF/ID.

## Interface
Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 0, PC value loaded by reset; must be 4-byte aligned.
- INC, 4, sequential increment.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset. Clock is CLK only.
- BUSY_WAIT  in  1  stall from instruction/data memory; PC holds while high.
- TRAP_EN  in  1  trap/exception redirect request, valid this cycle.
- TRAP_TARGET  in  XLEN  trap handler address.
- BRANCH_EN  in  1  taken branch/jump redirect request.
- BRANCH_TARGET  in  XLEN  branch/jump target.
- PC  out  XLEN  current fetch address (registered).
- PC_PLUS_INC  out  XLEN  combinational PC + INC, modulo 2^XLEN (link value).
- FETCH_VALID  out  1  registered; 0 in reset and for the cycle after reset's edge, 1 afterwards.
- FLUSH  out  1  registered one-cycle pulse: a redirect was loaded into PC at the last edge.
- MISALIGN  out  1  registered one-cycle pulse: the applied redirect target had bits [1:0] != 0.
- PEND_VALID  out  1  registered; a buffered redirect is waiting.

## Operation
- Internal state: PC register; pending buffer {pend_valid, pend_trap, pend_target}.
- Incoming request this cycle: TRAP_EN beats BRANCH_EN. If neither is set, there is no request.
- BUSY_WAIT=1:
  - PC holds.
  - FLUSH=0 and MISALIGN=0.
  - A request is written into the pending buffer as follows:
    - A trap always overwrites the buffer.
    - A branch writes only if the buffer is empty or holds a branch. The newer branch overwrites.
    - A branch never overwrites a pending trap.
- BUSY_WAIT=0, source select priority:
  1. TRAP_EN
  2. pending buffer
  3. BRANCH_EN
  4. PC + INC
- Redirect applied (priorities 1–3):
  - PC <= target with bits [1:0] forced to 0.
  - FLUSH <= 1.
  - MISALIGN <= (target[1:0] != 0).
  - Pending buffer cleared.
- Sequential step: PC <= PC + INC, FLUSH <= 0, MISALIGN <= 0. Pending buffer is already empty in this case.
- If BRANCH_EN loses to TRAP_EN or to the pending buffer while not busy, the branch is dropped, not buffered.
- Arithmetic: all additions are XLEN bits and wrap; no carry is kept.
- RESET (highest priority, sampled at rising edge):
  - PC <= RESET_VECTOR.
  - pend_valid <= 0.
  - FLUSH <= 0, MISALIGN <= 0, FETCH_VALID <= 0.
  - BUSY_WAIT and redirect inputs are ignored in that cycle.
  - Reset mid-stall discards any pending redirect.

## Timing
- All state updates occur at the CLK rising edge. Nothing is asynchronous.
- Latency:
  - A redirect input sampled at edge N appears on PC after edge N, i.e. one cycle.
  - FLUSH and MISALIGN are high during the cycle following that edge.
- Buffered redirect: applied at the first edge where BUSY_WAIT=0, unless a simultaneous TRAP_EN overrides it.
- PC_PLUS_INC follows PC combinationally within the same cycle.
- After reset deasserts, the first edge releases FETCH_VALID=1. The PC then reads RESET_VECTOR, with no negative pre-increment value.
- Boundary cases:
  - PC = 2^XLEN − INC steps to 0.
  - TRAP_EN and BRANCH_EN in the same cycle: the trap wins.
  - TRAP_EN and BRANCH_EN with BUSY_WAIT=1: the trap is stored and the branch is discarded.

## Test plan
- Reset/sequence: RESET=1 for 2 cycles, then release. PC=0x00000000 and FETCH_VALID=0 in reset. Then PC 0x0, 0x4, 0x8 on successive edges with FETCH_VALID=1.
- Branch: at PC=0x8, BRANCH_EN=1 with target 0x100. Next cycle PC=0x100 and FLUSH=1. Then PC=0x104 and FLUSH=0.
- Stall + buffer:
  - BUSY_WAIT=1 for 3 cycles with BRANCH_EN=1 target 0x200 in the first. PC frozen and PEND_VALID=1.
  - BUSY_WAIT drops; next edge PC=0x200, FLUSH=1, PEND_VALID=0.
- Priority:
  - During stall, trap 0x80 then branch 0x300 are requested. After release, PC=0x80.
  - Not busy, TRAP_EN and BRANCH_EN together: PC=TRAP_TARGET.
- Misalign/wrap:
  - Branch to 0x1002: PC=0x1000, MISALIGN=1 for one cycle.
  - Force PC=0xFFFFFFFC via redirect; next sequential PC=0x00000000.
- Reset mid-stall: pending branch 0x400 with BUSY_WAIT=1, assert RESET. PC=RESET_VECTOR, PEND_VALID=0, and 0x400 is never loaded.
